// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: bus widths, stall
// encoding, load opcode bits and the packed EX->MEM bus layout.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 147;
    localparam int MEM_TO_WB_WD = 136;
    localparam int MEM_TO_RF_WD = 38;
    localparam int STALL_BUS    = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    localparam int MEM_LB  = 4;
    localparam int MEM_LBU = 3;
    localparam int MEM_LH  = 2;
    localparam int MEM_LHU = 1;
    localparam int MEM_LW  = 0;

    localparam logic [4:0] OP_LB  = 5'b1 << MEM_LB;
    localparam logic [4:0] OP_LBU = 5'b1 << MEM_LBU;
    localparam logic [4:0] OP_LH  = 5'b1 << MEM_LH;
    localparam logic [4:0] OP_LHU = 5'b1 << MEM_LHU;
    localparam logic [4:0] OP_LW  = 5'b1 << MEM_LW;

    typedef struct packed {
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    typedef struct packed {
        hilo_t       hilo;
        logic [4:0]  mem_op;
        logic [31:0] pc;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data alignment: picks the addressed byte/halfword out of
// the little-endian SRAM word and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [4:0]  mem_op,
    input  logic [1:0]  off,
    input  logic [31:0] raw,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select and extension; halfwords look only at off[1].
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        load_data = 32'h0000_0000;
        case (off)
            2'd0:    byte_s = raw[7:0];
            2'd1:    byte_s = raw[15:8];
            2'd2:    byte_s = raw[23:16];
            2'd3:    byte_s = raw[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off[1]) begin
            half_s = raw[31:16];
        end else begin
            half_s = raw[15:0];
        end
        case (mem_op)
            OP_LB:   load_data = sext8(byte_s);
            OP_LBU:  load_data = {24'h000000, byte_s};
            OP_LH:   load_data = sext16(half_s);
            OP_LHU:  load_data = {16'h0000, half_s};
            OP_LW:   load_data = raw;
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus, aligns load data (with a
// one-entry hold so stalled loads keep their first-cycle SRAM data) and
// builds the WB, register-file forwarding and HI/LO forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus,
    output logic [65:0]             mem_to_ex_hilo
);

    ex_to_mem_t  bus_q, bus_d;
    logic        first_q, first_d;
    logic        hold_v_q, hold_v_d;
    logic [31:0] rdata_hold_q, rdata_hold_d;

    logic [31:0] raw_s;
    logic [31:0] load_data_s;
    logic        is_load_s;
    logic [31:0] rf_wdata_s;
    logic        unused_s;

    // Next-state: bubble, load, or hold; the first stalled cycle captures SRAM data.
    always_comb begin
        bus_d        = bus_q;
        first_d      = 1'b0;
        hold_v_d     = hold_v_q;
        rdata_hold_d = rdata_hold_q;
        if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP) begin
            bus_d    = '0;
            first_d  = 1'b1;
            hold_v_d = 1'b0;
        end else if (stall[STALL_MEM] == NO_STOP) begin
            bus_d    = ex_to_mem_t'(ex_to_mem_bus);
            first_d  = 1'b1;
            hold_v_d = 1'b0;
        end else begin
            if (first_q) begin
                rdata_hold_d = data_sram_rdata;
                hold_v_d     = 1'b1;
            end else begin
                rdata_hold_d = rdata_hold_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q        <= '0;
            first_q      <= 1'b0;
            hold_v_q     <= 1'b0;
            rdata_hold_q <= 32'h0000_0000;
        end else begin
            bus_q        <= bus_d;
            first_q      <= first_d;
            hold_v_q     <= hold_v_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    // Later stalled cycles must not see SRAM data for whatever address EX now drives.
    always_comb begin
        if (hold_v_q) begin
            raw_s = rdata_hold_q;
        end else begin
            raw_s = data_sram_rdata;
        end
    end

    load_align u_load_align (
        .mem_op    (bus_q.mem_op),
        .off       (bus_q.ex_result[1:0]),
        .raw       (raw_s),
        .load_data (load_data_s)
    );

    // Write-back value select.
    always_comb begin
        is_load_s = |bus_q.mem_op;
        if (bus_q.sel_rf_res && is_load_s) begin
            rf_wdata_s = load_data_s;
        end else begin
            rf_wdata_s = bus_q.ex_result;
        end
    end

    assign mem_to_rf_bus  = {bus_q.rf_we, bus_q.rf_waddr, rf_wdata_s};
    assign mem_to_wb_bus  = {bus_q.hilo, bus_q.pc, bus_q.rf_we, bus_q.rf_waddr, rf_wdata_s};
    assign mem_to_ex_hilo = bus_q.hilo;

    // Store controls belong to EX's SRAM request; upstream stall bits are not ours.
    assign unused_s = ^{bus_q.data_ram_en, bus_q.data_ram_wen,
                        stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment/extension, read-data hold under
// stall, bubbles, ALU pass-through and reset mid-stall.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [146:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [135:0] mem_to_wb_bus;
    logic [37:0]  mem_to_rf_bus;
    logic [65:0]  mem_to_ex_hilo;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0] LB  = 5'b10000;
    localparam logic [4:0] LBU = 5'b01000;
    localparam logic [4:0] LH  = 5'b00100;
    localparam logic [4:0] LHU = 5'b00010;
    localparam logic [4:0] LW  = 5'b00001;
    localparam logic [5:0] GO     = 6'b000000;
    localparam logic [5:0] HOLD   = 6'b011000;
    localparam logic [5:0] BUBBLE = 6'b001000;
    localparam logic [65:0] HILO  = {1'b1, 1'b1, 32'hAAAA_0000, 32'h0000_5555};

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_rf_bus   (mem_to_rf_bus),
        .mem_to_ex_hilo  (mem_to_ex_hilo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [146:0] mk(input logic [65:0] hilo, input logic [4:0] op,
                                        input logic [31:0] pc, input logic sel,
                                        input logic we, input logic [4:0] wa,
                                        input logic [31:0] res);
        return {hilo, op, pc, |op, 4'h0, sel, we, wa, res};
    endfunction

    // Present a load to EX, advance into MEM, then drive the SRAM word.
    task automatic do_load(input logic [4:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic sel);
        stall         = GO;
        ex_to_mem_bus = mk(66'h0, op, 32'h0040_0000, sel, 1'b1, 5'd3, addr);
        step();
        data_sram_rdata = rdata;
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        stall           = GO;
        ex_to_mem_bus   = '0;
        data_sram_rdata = 32'h1111_1111;
        step();
        step();
        check("rst_wb",   mem_to_wb_bus,  136'h0);
        check("rst_rf",   mem_to_rf_bus,  136'h0);
        check("rst_hilo", mem_to_ex_hilo, 136'h0);
        check("rst_holdv", dut.hold_v_q,  136'h0);
        rst = 1'b0;

        // Byte and halfword alignment / extension.
        do_load(LB, 32'h0000_1003, 32'h80FF_1234, 1'b1);
        check("lb_off3", mem_to_rf_bus, {1'b1, 5'd3, 32'hFFFF_FF80});
        do_load(LBU, 32'h0000_1003, 32'h80FF_1234, 1'b1);
        check("lbu_off3", mem_to_rf_bus[31:0], 32'h0000_0080);
        do_load(LB, 32'h0000_1001, 32'h80FF_1234, 1'b1);
        check("lb_off1", mem_to_rf_bus[31:0], 32'h0000_0012);
        do_load(LB, 32'h0000_1002, 32'h80FF_1234, 1'b1);
        check("lb_off2", mem_to_rf_bus[31:0], 32'hFFFF_FFFF);
        do_load(LBU, 32'h0000_1000, 32'h80FF_1234, 1'b1);
        check("lbu_off0", mem_to_rf_bus[31:0], 32'h0000_0034);
        do_load(LH, 32'h0000_1002, 32'h8001_ABCD, 1'b1);
        check("lh_hi", mem_to_rf_bus[31:0], 32'hFFFF_8001);
        do_load(LH, 32'h0000_1003, 32'h8001_ABCD, 1'b1);
        check("lh_a0_ignored", mem_to_rf_bus[31:0], 32'hFFFF_8001);
        do_load(LHU, 32'h0000_1000, 32'h8001_ABCD, 1'b1);
        check("lhu_lo", mem_to_rf_bus[31:0], 32'h0000_ABCD);
        do_load(LH, 32'h0000_1000, 32'h8001_ABCD, 1'b1);
        check("lh_lo_sext", mem_to_rf_bus[31:0], 32'hFFFF_ABCD);
        do_load(LW, 32'h0000_1001, 32'hDEAD_BEEF, 1'b1);
        check("lw_misaligned", mem_to_rf_bus[31:0], 32'hDEAD_BEEF);
        do_load(LW, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
        check("load_sel0", mem_to_rf_bus[31:0], 32'h0000_1004);
        check("holdv_after_go", dut.hold_v_q, 136'h0);

        // Held lw across three stalled cycles while SRAM data and EX change.
        do_load(LW, 32'h0000_2000, 32'hDEAD_BEEF, 1'b1);
        stall = HOLD;
        ex_to_mem_bus = mk(66'h0, 5'h0, 32'h0040_0100, 1'b0, 1'b1, 5'd7, 32'h0000_0011);
        #1;
        check("hold_c1", mem_to_rf_bus[31:0], 32'hDEAD_BEEF);
        step();
        data_sram_rdata = 32'h0000_0000;
        #1;
        check("hold_c2", mem_to_rf_bus[31:0], 32'hDEAD_BEEF);
        check("holdv_set", dut.hold_v_q, 136'h1);
        step();
        check("hold_c3", mem_to_rf_bus[31:0], 32'hDEAD_BEEF);
        stall = GO;
        step();
        check("release_new", mem_to_rf_bus, {1'b1, 5'd7, 32'h0000_0011});
        check("release_holdv", dut.hold_v_q, 136'h0);

        // Bubble while a load is held.
        do_load(LW, 32'h0000_3000, 32'h1234_5678, 1'b1);
        stall = HOLD;
        step();
        stall = BUBBLE;
        step();
        check("bubble_wb", mem_to_wb_bus, 136'h0);
        check("bubble_rfwe", mem_to_rf_bus[37], 136'h0);
        check("bubble_holdv", dut.hold_v_q, 136'h0);

        // Non-load ALU op and HI/LO pass-through.
        stall = GO;
        ex_to_mem_bus = mk(HILO, 5'h0, 32'h0040_0200, 1'b1, 1'b1, 5'd5, 32'h1234_5678);
        step();
        data_sram_rdata = 32'hFFFF_FFFF;
        #1;
        check("alu_rf", mem_to_rf_bus, {1'b1, 5'd5, 32'h1234_5678});
        check("alu_hilo_ex", mem_to_ex_hilo, HILO);
        check("alu_wb", mem_to_wb_bus, {HILO, 32'h0040_0200, 1'b1, 5'd5, 32'h1234_5678});

        // Reset during a held load, then a fresh load uses live data.
        do_load(LW, 32'h0000_4000, 32'hCAFE_F00D, 1'b1);
        stall = HOLD;
        step();
        check("pre_rst_hold", mem_to_rf_bus[31:0], 32'hCAFE_F00D);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_wb", mem_to_wb_bus, 136'h0);
        check("midrst_hilo", mem_to_ex_hilo, 136'h0);
        check("midrst_holdv", dut.hold_v_q, 136'h0);
        do_load(LW, 32'h0000_5000, 32'h0102_0304, 1'b1);
        check("post_rst_live", mem_to_rf_bus[31:0], 32'h0102_0304);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the five-stage MIPS core, directly downstream of EX. It registers the EX→MEM bus, aligns and sign/zero-extends load data returned by the synchronous data SRAM, and selects the register-file write-back value. It forwards the write-back result and pending HI/LO writes to the earlier stages, and passes everything to WB. A one-entry read-data hold register keeps load data correct while MEM is stalled.

## Interface
- No parameters; widths come from the shared defines: `EX_TO_MEM_WD`=147, `MEM_TO_WB_WD`=136, `MEM_TO_RF_WD`=38, `StallBus`=6.
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  6  pipeline stall vector; bit 3 = MEM, bit 4 = WB; `Stop`=1, `NoStop`=0
- ex_to_mem_bus  in  147  {hilo_bus[146:81], mem_op[80:76], pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- data_sram_rdata  in  32  SRAM read data, valid the cycle after EX presented the address
- mem_to_wb_bus  out  136  {hilo_bus[135:70], pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}
- mem_to_rf_bus  out  38  {rf_we, rf_waddr, rf_wdata}, forwarding to ID
- mem_to_ex_hilo  out  66  {hi_we, lo_we, hi[31:0], lo[31:0]}, HI/LO forwarding to EX

## Operation
- Pipeline register `bus_r`, priority order:
  - rst → all zero.
  - stall[3]=Stop and stall[4]=NoStop → all zero (bubble).
  - stall[3]=NoStop → load ex_to_mem_bus.
  - Otherwise hold.
- mem_op is one-hot {lb, lbu, lh, lhu, lw}, bits 4..0. All zero means not a load.
- addr = ex_result; off = addr[1:0]. Byte order is little-endian.
- Byte select by off: 0→raw[7:0], 1→[15:8], 2→[23:16], 3→[31:24].
  - lb sign-extends the selected byte; lbu zero-extends it.
- Halfword select by addr[1] only: 0→raw[15:0], 1→raw[31:16]. addr[0] is ignored.
  - lh sign-extends; lhu zero-extends.
- lw returns raw unchanged; addr[1:0] is ignored. Misalignment raises no exception.
- rf_wdata = (sel_rf_res and a load bit set) ? load_data : ex_result.
- hilo_bus passes through unchanged to mem_to_wb_bus and mem_to_ex_hilo.
- Read-data hold:
  - `first` flag is set to 1 on every bus_r load (including bubble); otherwise cleared.
  - `hold_v` and `rdata_hold` behave as follows:
    - Cycle with first=1 and stall[3]=Stop: capture rdata_hold ← data_sram_rdata and set hold_v=1.
    - Any bus_r load or bubble: clear hold_v.
    - rst: clear both.
  - raw = hold_v ? rdata_hold : data_sram_rdata.

## Timing
- Reset: bus_r, rdata_hold, hold_v and first are all 0. Consequently all outputs are 0 (rf_we=0, hi_we=lo_we=0).
- Latency: one cycle from ex_to_mem_bus to the outputs. rf_wdata is combinational from bus_r and raw in the same cycle.
- The SRAM returns data in the first MEM cycle of a load. Later stalled cycles must use rdata_hold, because EX may drive a new address.
- Stall released in the same cycle as capture: the new bus loads and hold_v is cleared; the loaded value wins over the captured one.
- Bubble while a load is held: hold_v clears and the outputs go to zero next cycle.
- rst asserted mid-stall: everything clears on that edge regardless of stall.

## Structure
- Shared defines (`lib/defines.vh`):
  - bus widths
  - `Stop`/`NoStop`
  - mem_op bit positions: `MEM_LB`=4, `MEM_LBU`=3, `MEM_LH`=2, `MEM_LHU`=1, `MEM_LW`=0.
- One sub-module, `load_align`: combinational {mem_op, off, raw} → load_data. This keeps the extension logic independently testable.
- Sequential state stays in mem_stage.

## Test plan
- lb, addr=0x1003, rdata=0x80FF1234, sel_rf_res=1 → rf_wdata=0xFFFFFF80. Same case with lbu → 0x00000080.
- lh, addr=0x1002, rdata=0x8001ABCD → rf_wdata=0xFFFF8001. lhu at addr 0x1000 → 0x0000ABCD.
- lw, rdata=0xDEADBEEF, stall[3]=Stop for 3 cycles with rdata changing to 0x0 after cycle 1 → rf_wdata stays 0xDEADBEEF throughout.
- stall=6'b001000 (MEM stop, WB go) → next cycle rf_we=0 and mem_to_wb_bus=0.
- Non-load ALU op, ex_result=0x12345678, rf_we=1, rf_waddr=5 → mem_to_rf_bus={1,5,0x12345678}. hilo_bus {1,1,0xAAAA0000,0x5555} appears unchanged on both hilo outputs.
- rst asserted during a held load → next cycle all outputs are 0 and hold_v=0. The first load after reset uses live data_sram_rdata.
